// File: rtl/ysyx_22041207_pkg.sv
// Shared encodings for the memory arbiter: FSM states and transaction owner.
package ysyx_22041207_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } arb_state_t;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_LS = 1'b1
  } owner_t;

endpackage

// File: rtl/ysyx_22041207_mem_arb.sv
// Two-port (fetch / load-store) arbiter onto a single memory port, one transaction
// outstanding, LSU priority with a starvation bound for fetch and fetch flush support.
module ysyx_22041207_mem_arb
  import ysyx_22041207_pkg::*;
#(
  parameter int ADDR_W     = 64,
  parameter int DATA_W     = 64,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req_valid,
  output logic              if_req_ready,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              flush,
  output logic              if_resp_valid,
  output logic [DATA_W-1:0] if_resp_data,
  input  logic              ls_req_valid,
  output logic              ls_req_ready,
  input  logic              ls_wen,
  input  logic [ADDR_W-1:0] ls_addr,
  input  logic [DATA_W-1:0] ls_wdata,
  input  logic [7:0]        ls_wmask,
  output logic              ls_resp_valid,
  output logic [DATA_W-1:0] ls_resp_data,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_wen,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [7:0]        mem_wmask,
  input  logic              mem_resp_valid,
  input  logic [DATA_W-1:0] mem_resp_data
);

  localparam int CNT_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

  arb_state_t       state;
  owner_t           owner;
  logic [CNT_W-1:0] starve_cnt;
  logic             drop;

  logic in_idle;
  logic if_live;
  logic grant_ls;
  logic resp_hit;

  // Arbitration and response steering; readies are forced low while rst is held.
  always_comb begin
    in_idle       = (state == ST_IDLE) && !rst;
    if_live       = if_req_valid && !flush;
    grant_ls      = ls_req_valid && !(if_live && (starve_cnt == CNT_MAX));
    ls_req_ready  = in_idle && ls_req_valid && grant_ls;
    if_req_ready  = in_idle && if_live && !grant_ls;
    mem_req_valid = (state == ST_REQ) && !rst;
    resp_hit      = (state == ST_WAIT) && mem_resp_valid && !rst;
    ls_resp_valid = resp_hit && (owner == OWN_LS);
    if_resp_valid = resp_hit && (owner == OWN_IF) && !drop && !flush;
    ls_resp_data  = ls_resp_valid ? mem_resp_data : '0;
    if_resp_data  = if_resp_valid ? mem_resp_data : '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      owner      <= OWN_IF;
      starve_cnt <= '0;
      drop       <= 1'b0;
      mem_addr   <= '0;
      mem_wen    <= 1'b0;
      mem_wdata  <= '0;
      mem_wmask  <= '0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (ls_req_ready) begin
            owner     <= OWN_LS;
            mem_addr  <= ls_addr;
            mem_wen   <= ls_wen;
            mem_wdata <= ls_wdata;
            mem_wmask <= ls_wmask;
            state     <= ST_REQ;
            if (if_live && (starve_cnt != CNT_MAX)) starve_cnt <= starve_cnt + CNT_W'(1);
          end else if (if_req_ready) begin
            owner      <= OWN_IF;
            mem_addr   <= if_addr;
            mem_wen    <= 1'b0;
            mem_wdata  <= '0;
            mem_wmask  <= '0;
            state      <= ST_REQ;
            starve_cnt <= '0;
          end
        end
        ST_REQ: begin
          if (flush && (owner == OWN_IF)) drop <= 1'b1;
          if (mem_req_ready) state <= ST_WAIT;
        end
        ST_WAIT: begin
          // The transaction always completes downstream; a flushed fetch just loses its pulse.
          if (flush && (owner == OWN_IF)) drop <= 1'b1;
          if (mem_resp_valid) begin
            state <= ST_IDLE;
            drop  <= 1'b0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_22041207_mem_arb.sv
// Bench for ysyx_22041207_mem_arb: arbitration table, scoreboarded responses, flush/reset corners.
module tb_ysyx_22041207_mem_arb;

  logic        clk;
  logic        rst;
  logic        if_req_valid, if_req_ready, flush, if_resp_valid;
  logic [63:0] if_addr, if_resp_data;
  logic        ls_req_valid, ls_req_ready, ls_wen, ls_resp_valid;
  logic [63:0] ls_addr, ls_wdata, ls_resp_data;
  logic [7:0]  ls_wmask;
  logic        mem_req_valid, mem_req_ready, mem_wen, mem_resp_valid;
  logic [63:0] mem_addr, mem_wdata, mem_resp_data;
  logic [7:0]  mem_wmask;

  logic        auto_mem, auto_v, man_v, mon_en;
  logic [63:0] auto_d, man_d;

  assign mem_resp_valid = auto_mem ? auto_v : man_v;
  assign mem_resp_data  = auto_mem ? auto_d : man_d;

  ysyx_22041207_mem_arb dut (
    .clk(clk), .rst(rst),
    .if_req_valid(if_req_valid), .if_req_ready(if_req_ready), .if_addr(if_addr),
    .flush(flush), .if_resp_valid(if_resp_valid), .if_resp_data(if_resp_data),
    .ls_req_valid(ls_req_valid), .ls_req_ready(ls_req_ready), .ls_wen(ls_wen),
    .ls_addr(ls_addr), .ls_wdata(ls_wdata), .ls_wmask(ls_wmask),
    .ls_resp_valid(ls_resp_valid), .ls_resp_data(ls_resp_data),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_addr(mem_addr), .mem_wen(mem_wen), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
    .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic is_ls;
    logic [63:0] data;
  } exp_t;

  typedef struct packed {
    logic if_v;
    logic fl;
    logic ls_v;
    logic exp_if;
    logic exp_ls;
  } vec_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endfunction

  function automatic logic [63:0] mem_word(input logic [63:0] a);
    if (a == 64'h8000_0000) return 64'h0000_0013;
    return {a[31:0], ~a[31:0]};
  endfunction

  // Memory model: answers one cycle after each request handshake.
  initial begin
    logic        hs;
    logic [63:0] ha;
    auto_v = 1'b0;
    auto_d = 64'h0;
    forever begin
      @(negedge clk);
      hs = mem_req_valid && mem_req_ready;
      ha = mem_addr;
      @(posedge clk);
      #1;
      auto_v = hs;
      if (hs) auto_d = mem_word(ha);
    end
  end

  // Response monitor: every response pulse is matched against the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (if_resp_valid || ls_resp_valid) begin
          if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_resp actual if=%0b ls=%0b required none", if_resp_valid, ls_resp_valid);
          end else begin
            e = sb.pop_front();
            check("resp_both_valid", 64'(if_resp_valid && ls_resp_valid), 64'd0);
            check("resp_owner", 64'(ls_resp_valid), 64'(e.is_ls));
            check("resp_data", ls_resp_valid ? ls_resp_data : if_resp_data, e.data);
          end
        end
        if (!if_resp_valid) check("if_data_zero", if_resp_data, 64'd0);
        if (!ls_resp_valid) check("ls_data_zero", ls_resp_data, 64'd0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "simulation time limit");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string name);
    int c = 0;
    while (sb.size() != 0 && c < 50) begin
      tick();
      c++;
    end
    check(name, 64'(sb.size()), 64'd0);
    sb.delete();
  endtask

  vec_t vecs[8];
  logic g[10];
  logic exp_g[10];

  initial begin
    int n;
    logic got;

    vecs[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[2] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[3] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[4] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    vecs[6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    vecs[7] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    exp_g = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

    mon_en = 1'b0;
    auto_mem = 1'b1;
    man_v = 1'b0;
    man_d = 64'h0;
    rst = 1'b1;
    if_req_valid = 1'b1;
    ls_req_valid = 1'b1;
    flush = 1'b0;
    if_addr = 64'h8000_0000;
    ls_addr = 64'h0;
    ls_wen = 1'b0;
    ls_wdata = 64'h0;
    ls_wmask = 8'h0;
    mem_req_ready = 1'b1;

    // Reset: everything quiet even with requests pending.
    #2;
    check("rst_if_ready", 64'(if_req_ready), 64'd0);
    check("rst_ls_ready", 64'(ls_req_ready), 64'd0);
    check("rst_mem_valid", 64'(mem_req_valid), 64'd0);
    check("rst_mem_addr", mem_addr, 64'd0);
    check("rst_mem_wmask", 64'(mem_wmask), 64'd0);
    if_req_valid = 1'b0;
    ls_req_valid = 1'b0;
    repeat (2) tick();
    rst = 1'b0;
    mon_en = 1'b1;
    tick();

    // Combinational arbitration in IDLE with starve_cnt = 0; valids drop before the edge.
    for (int i = 0; i < 8; i++) begin
      if_req_valid = vecs[i].if_v;
      flush = vecs[i].fl;
      ls_req_valid = vecs[i].ls_v;
      @(negedge clk);
      check($sformatf("tbl%0d_if_ready", i), 64'(if_req_ready), 64'(vecs[i].exp_if));
      check($sformatf("tbl%0d_ls_ready", i), 64'(ls_req_ready), 64'(vecs[i].exp_ls));
      check($sformatf("tbl%0d_mem_valid", i), 64'(mem_req_valid), 64'd0);
      #1;
      if_req_valid = 1'b0;
      flush = 1'b0;
      ls_req_valid = 1'b0;
      tick();
    end

    // Single fetch: request next cycle, response two cycles after accept.
    if_req_valid = 1'b1;
    if_addr = 64'h8000_0000;
    @(negedge clk);
    check("if1_ready", 64'(if_req_ready), 64'd1);
    sb.push_back('{1'b0, 64'h13});
    tick();
    if_req_valid = 1'b0;
    @(negedge clk);
    check("if1_mem_valid", 64'(mem_req_valid), 64'd1);
    check("if1_mem_addr", mem_addr, 64'h8000_0000);
    check("if1_mem_wen", 64'(mem_wen), 64'd0);
    @(negedge clk);
    check("if1_resp_valid", 64'(if_resp_valid), 64'd1);
    check("if1_resp_data", if_resp_data, 64'h13);
    tick();
    drain("if1_drain");

    // Simultaneous requests: LSU first, fetch right after the LSU response.
    if_req_valid = 1'b1;
    if_addr = 64'h8000_0040;
    ls_req_valid = 1'b1;
    ls_wen = 1'b0;
    ls_addr = 64'h8000_2000;
    @(negedge clk);
    check("both_ls_ready", 64'(ls_req_ready), 64'd1);
    check("both_if_ready", 64'(if_req_ready), 64'd0);
    sb.push_back('{1'b1, mem_word(64'h8000_2000)});
    tick();
    ls_req_valid = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (if_req_ready) begin
        got = 1'b1;
        check("if_after_ls_sb_empty", 64'(sb.size()), 64'd0);
        sb.push_back('{1'b0, mem_word(64'h8000_0040)});
      end
      tick();
    end
    if_req_valid = 1'b0;
    check("if_after_ls_granted", 64'(got), 64'd1);
    drain("both_drain");

    // Both held valid: four LSU grants, one fetch, then the pattern repeats.
    if_req_valid = 1'b1;
    if_addr = 64'h8000_0100;
    ls_req_valid = 1'b1;
    ls_addr = 64'h8000_3000;
    n = 0;
    for (int c = 0; c < 300 && n < 10; c++) begin
      @(negedge clk);
      got = 1'b0;
      if (ls_req_ready || if_req_ready) begin
        g[n] = ls_req_ready;
        got = ls_req_ready;
        sb.push_back('{ls_req_ready, mem_word(ls_req_ready ? ls_addr : if_addr)});
        n++;
      end
      tick();
      if (got) ls_addr = ls_addr + 64'd8;
    end
    if_req_valid = 1'b0;
    ls_req_valid = 1'b0;
    check("starve_grant_count", 64'(n), 64'd10);
    for (int i = 0; i < n; i++) check($sformatf("starve_grant%0d", i), 64'(g[i]), 64'(exp_g[i]));
    drain("starve_drain");

    // Flush while a fetch waits: the response is swallowed, FSM returns to IDLE.
    auto_mem = 1'b0;
    if_req_valid = 1'b1;
    if_addr = 64'h8000_0200;
    @(negedge clk);
    check("fl_if_ready", 64'(if_req_ready), 64'd1);
    tick();
    if_req_valid = 1'b0;
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    man_v = 1'b1;
    man_d = 64'hDEAD_BEEF;
    @(negedge clk);
    check("fl_if_resp_valid", 64'(if_resp_valid), 64'd0);
    check("fl_if_resp_data", if_resp_data, 64'd0);
    tick();
    man_v = 1'b0;
    if_req_valid = 1'b1;
    @(negedge clk);
    check("fl_idle_after", 64'(if_req_ready), 64'd1);
    #1;
    if_req_valid = 1'b0;
    tick();

    // Flush in the same cycle as the fetch response.
    if_req_valid = 1'b1;
    if_addr = 64'h8000_0300;
    @(negedge clk);
    check("fl2_if_ready", 64'(if_req_ready), 64'd1);
    tick();
    if_req_valid = 1'b0;
    tick();
    flush = 1'b1;
    man_v = 1'b1;
    man_d = 64'h1234_5678;
    @(negedge clk);
    check("fl2_if_resp_valid", 64'(if_resp_valid), 64'd0);
    tick();
    flush = 1'b0;
    man_v = 1'b0;

    // Store with backpressure and a flush during WAIT: still completes and responds.
    ls_req_valid = 1'b1;
    ls_wen = 1'b1;
    ls_addr = 64'h8000_1000;
    ls_wdata = 64'h1122_3344_5566_7788;
    ls_wmask = 8'h0F;
    mem_req_ready = 1'b0;
    @(negedge clk);
    check("st_ls_ready", 64'(ls_req_ready), 64'd1);
    tick();
    ls_req_valid = 1'b0;
    ls_wen = 1'b0;
    ls_wdata = 64'h0;
    ls_wmask = 8'h0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check($sformatf("st_hold%0d_valid", i), 64'(mem_req_valid), 64'd1);
      check($sformatf("st_hold%0d_addr", i), mem_addr, 64'h8000_1000);
      check($sformatf("st_hold%0d_wen", i), 64'(mem_wen), 64'd1);
      check($sformatf("st_hold%0d_wdata", i), mem_wdata, 64'h1122_3344_5566_7788);
      check($sformatf("st_hold%0d_wmask", i), 64'(mem_wmask), 64'h0F);
      tick();
    end
    mem_req_ready = 1'b1;
    tick();
    flush = 1'b1;
    @(negedge clk);
    check("st_wait_mem_valid", 64'(mem_req_valid), 64'd0);
    tick();
    man_v = 1'b1;
    man_d = 64'h0000_CAFE;
    sb.push_back('{1'b1, 64'h0000_CAFE});
    @(negedge clk);
    check("st_resp_valid", 64'(ls_resp_valid), 64'd1);
    check("st_resp_data", ls_resp_data, 64'h0000_CAFE);
    tick();
    man_v = 1'b0;
    flush = 1'b0;
    drain("st_drain");

    // Reset during WAIT: the later stray response is ignored.
    if_req_valid = 1'b1;
    if_addr = 64'h8000_0400;
    @(negedge clk);
    check("rw_if_ready", 64'(if_req_ready), 64'd1);
    tick();
    if_req_valid = 1'b0;
    tick();
    @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("rw_mem_valid", 64'(mem_req_valid), 64'd0);
    check("rw_mem_addr", mem_addr, 64'd0);
    tick();
    rst = 1'b0;
    man_v = 1'b1;
    man_d = 64'h5555_AAAA;
    @(negedge clk);
    check("rw_if_resp_valid", 64'(if_resp_valid), 64'd0);
    check("rw_ls_resp_valid", 64'(ls_resp_valid), 64'd0);
    check("rw_mem_valid2", 64'(mem_req_valid), 64'd0);
    tick();
    man_v = 1'b0;
    if_req_valid = 1'b1;
    @(negedge clk);
    check("rw_idle_after", 64'(if_req_ready), 64'd1);
    #1;
    if_req_valid = 1'b0;
    tick();

    check("sb_empty_end", 64'(sb.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
